// File: rtl/mandelbrot_ctrl_pkg.sv
// Shared definitions for the mandelbrot kernel AXI4-Lite control slave:
// register offsets, AP_CTRL bit positions, FSM state types and a byte-strobe merge helper.
package mandelbrot_ctrl_pkg;

    localparam int AXI_ADDR_W = 12;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_STRB_W = AXI_DATA_W / 8;

    // Only the low six address bits are decoded; higher bits alias.
    localparam logic [5:0] ADDR_AP_CTRL     = 6'h00;
    localparam logic [5:0] ADDR_GIE         = 6'h04;
    localparam logic [5:0] ADDR_IER         = 6'h08;
    localparam logic [5:0] ADDR_ISR         = 6'h0C;
    localparam logic [5:0] ADDR_CTRL_LENGTH = 6'h10;
    localparam logic [5:0] ADDR_A_LO        = 6'h18;
    localparam logic [5:0] ADDR_A_HI        = 6'h1C;

    localparam int AP_START_BIT        = 0;
    localparam int AP_DONE_BIT         = 1;
    localparam int AP_IDLE_BIT         = 2;
    localparam int AP_READY_BIT        = 3;
    localparam int AP_AUTO_RESTART_BIT = 7;

    typedef enum logic [1:0] {
        WRIDLE = 2'd0,
        WRDATA = 2'd1,
        WRRESP = 2'd2
    } wr_state_e;

    typedef enum logic {
        RDIDLE = 1'b0,
        RDDATA = 1'b1
    } rd_state_e;

    // Merge new write data into an old register value, one byte per strobe bit.
    function automatic logic [AXI_DATA_W-1:0] apply_strb(
        input logic [AXI_DATA_W-1:0] old_val,
        input logic [AXI_DATA_W-1:0] new_val,
        input logic [AXI_STRB_W-1:0] strb
    );
        logic [AXI_DATA_W-1:0] merged;
        for (int i = 0; i < AXI_STRB_W; i++) begin
            merged[i*8 +: 8] = strb[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/mandelbrot_control_s_axi_if.sv
// AXI4-Lite control-port bundle between the host-side initiator and the kernel control slave.
interface mandelbrot_control_s_axi_if;
    import mandelbrot_ctrl_pkg::*;

    logic                  awvalid;
    logic                  awready;
    logic [AXI_ADDR_W-1:0] awaddr;
    logic                  wvalid;
    logic                  wready;
    logic [AXI_DATA_W-1:0] wdata;
    logic [AXI_STRB_W-1:0] wstrb;
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;
    logic                  arvalid;
    logic                  arready;
    logic [AXI_ADDR_W-1:0] araddr;
    logic                  rvalid;
    logic                  rready;
    logic [AXI_DATA_W-1:0] rdata;
    logic [1:0]            rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

endinterface

// File: rtl/mandelbrot_control_s_axi.sv
// AXI4-Lite control slave for the mandelbrot kernel: ap_ctrl handshake, interrupt
// registers and the kernel arguments ctrl_length and a (64-bit pointer).
module mandelbrot_control_s_axi
    import mandelbrot_ctrl_pkg::*;
#(
    parameter int C_S_AXI_ADDR_WIDTH = 12,
    parameter int C_S_AXI_DATA_WIDTH = 32
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst,
    mandelbrot_control_s_axi_if.slave s_axi_control,
    output logic                     interrupt,
    output logic                     ap_start,
    input  logic                     ap_done,
    input  logic                     ap_idle,
    input  logic                     ap_ready,
    output logic [31:0]              ctrl_length,
    output logic [63:0]              a
);

    wr_state_e wstate;
    rd_state_e rstate;

    logic awready_q, wready_q, bvalid_q;
    logic arready_q, rvalid_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_next;
    logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr_w;
    logic [C_S_AXI_ADDR_WIDTH-1:0] araddr_w;
    logic [5:0] waddr_q;
    logic [5:0] raddr_q;

    logic auto_restart;
    logic done_q, ready_q, idle_q;
    logic gie;
    logic [1:0] ier;
    logic [1:0] isr;
    logic [1:0] isr_event;

    logic w_hs, ar_hs, rd_done, wr_ctrl_lo;

    assign awaddr_w = s_axi_control.awaddr;
    assign araddr_w = s_axi_control.araddr;

    // Upper address bits are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, awaddr_w[C_S_AXI_ADDR_WIDTH-1:6], araddr_w[C_S_AXI_ADDR_WIDTH-1:6]};

    assign w_hs       = wready_q & s_axi_control.wvalid;
    assign ar_hs      = arready_q & s_axi_control.arvalid;
    assign rd_done    = rvalid_q & s_axi_control.rready;
    assign wr_ctrl_lo = w_hs && (waddr_q == ADDR_AP_CTRL) && s_axi_control.wstrb[0];
    assign isr_event  = {ap_ready, ap_done};

    assign s_axi_control.awready = awready_q;
    assign s_axi_control.wready  = wready_q;
    assign s_axi_control.bvalid  = bvalid_q;
    assign s_axi_control.bresp   = 2'b00;
    assign s_axi_control.arready = arready_q;
    assign s_axi_control.rvalid  = rvalid_q;
    assign s_axi_control.rdata   = rdata_q;
    assign s_axi_control.rresp   = 2'b00;

    assign interrupt = gie & (|isr);

    // Write channel FSM: address, then data, then response; one write in flight.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            wstate    <= WRIDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            waddr_q   <= '0;
        end else begin
            case (wstate)
                WRIDLE: begin
                    if (awready_q && s_axi_control.awvalid) begin
                        waddr_q   <= awaddr_w[5:0];
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        wstate    <= WRDATA;
                    end else begin
                        awready_q <= 1'b1;
                    end
                end
                WRDATA: begin
                    if (s_axi_control.wvalid) begin
                        wready_q <= 1'b0;
                        bvalid_q <= 1'b1;
                        wstate   <= WRRESP;
                    end
                end
                WRRESP: begin
                    if (s_axi_control.bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wstate    <= WRIDLE;
                    end
                end
                default: begin
                    awready_q <= 1'b0;
                    wready_q  <= 1'b0;
                    bvalid_q  <= 1'b0;
                    wstate    <= WRIDLE;
                end
            endcase
        end
    end

    // Read data mux evaluated on the incoming read address.
    always_comb begin
        rdata_next = '0;
        case (araddr_w[5:0])
            ADDR_AP_CTRL: begin
                rdata_next[AP_START_BIT]        = ap_start;
                rdata_next[AP_DONE_BIT]         = done_q;
                rdata_next[AP_IDLE_BIT]         = idle_q;
                rdata_next[AP_READY_BIT]        = ready_q;
                rdata_next[AP_AUTO_RESTART_BIT] = auto_restart;
            end
            ADDR_GIE:         rdata_next[0]   = gie;
            ADDR_IER:         rdata_next[1:0] = ier;
            ADDR_ISR:         rdata_next[1:0] = isr;
            ADDR_CTRL_LENGTH: rdata_next      = ctrl_length;
            ADDR_A_LO:        rdata_next      = a[31:0];
            ADDR_A_HI:        rdata_next      = a[63:32];
            default:          rdata_next      = '0;
        endcase
    end

    // Read channel FSM: capture data on the address handshake, hold until accepted.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            rstate    <= RDIDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            raddr_q   <= '0;
        end else begin
            case (rstate)
                RDIDLE: begin
                    if (ar_hs) begin
                        rdata_q   <= rdata_next;
                        raddr_q   <= araddr_w[5:0];
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rstate    <= RDDATA;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                RDDATA: begin
                    if (s_axi_control.rready) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        rstate    <= RDIDLE;
                    end
                end
                default: begin
                    arready_q <= 1'b0;
                    rvalid_q  <= 1'b0;
                    rstate    <= RDIDLE;
                end
            endcase
        end
    end

    // Control/status, interrupt and kernel-argument registers.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            ap_start     <= 1'b0;
            auto_restart <= 1'b0;
            done_q       <= 1'b0;
            ready_q      <= 1'b0;
            idle_q       <= 1'b0;
            gie          <= 1'b0;
            ier          <= '0;
            isr          <= '0;
            ctrl_length  <= '0;
            a            <= '0;
        end else begin
            idle_q <= ap_idle;

            if (wr_ctrl_lo && s_axi_control.wdata[AP_START_BIT]) begin
                ap_start <= 1'b1;
            end else if (ap_ready && !auto_restart) begin
                ap_start <= 1'b0;
            end

            if (wr_ctrl_lo) begin
                auto_restart <= s_axi_control.wdata[AP_AUTO_RESTART_BIT];
            end

            // A new pulse beats a clear-on-read landing in the same cycle.
            if (ap_done) begin
                done_q <= 1'b1;
            end else if (rd_done && raddr_q == ADDR_AP_CTRL) begin
                done_q <= 1'b0;
            end

            if (ap_ready) begin
                ready_q <= 1'b1;
            end else if (rd_done && raddr_q == ADDR_AP_CTRL) begin
                ready_q <= 1'b0;
            end

            if (w_hs && waddr_q == ADDR_GIE && s_axi_control.wstrb[0]) begin
                gie <= s_axi_control.wdata[0];
            end

            if (w_hs && waddr_q == ADDR_IER && s_axi_control.wstrb[0]) begin
                ier <= s_axi_control.wdata[1:0];
            end

            for (int i = 0; i < 2; i++) begin
                if (isr_event[i] && ier[i]) begin
                    isr[i] <= 1'b1;
                end else if (w_hs && waddr_q == ADDR_ISR && s_axi_control.wstrb[0] && s_axi_control.wdata[i]) begin
                    isr[i] <= ~isr[i];
                end
            end

            if (w_hs && waddr_q == ADDR_CTRL_LENGTH) begin
                ctrl_length <= apply_strb(ctrl_length, s_axi_control.wdata, s_axi_control.wstrb);
            end

            if (w_hs && waddr_q == ADDR_A_LO) begin
                a[31:0] <= apply_strb(a[31:0], s_axi_control.wdata, s_axi_control.wstrb);
            end

            if (w_hs && waddr_q == ADDR_A_HI) begin
                a[63:32] <= apply_strb(a[63:32], s_axi_control.wdata, s_axi_control.wstrb);
            end
        end
    end

endmodule

// File: tb/tb_mandelbrot_control_s_axi.sv
// Directed bench for the mandelbrot AXI4-Lite control slave.
module tb_mandelbrot_control_s_axi;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        interrupt;
    logic        ap_start;
    logic        ap_done;
    logic        ap_idle;
    logic        ap_ready;
    logic [31:0] ctrl_length;
    logic [63:0] a;

    int errors = 0;
    int checks = 0;

    localparam int TIMEOUT = 50;

    mandelbrot_control_s_axi_if axi ();

    mandelbrot_control_s_axi dut (
        .ap_clk        (ap_clk),
        .ap_rst        (ap_rst),
        .s_axi_control (axi),
        .interrupt     (interrupt),
        .ap_start      (ap_start),
        .ap_done       (ap_done),
        .ap_idle       (ap_idle),
        .ap_ready      (ap_ready),
        .ctrl_length   (ctrl_length),
        .a             (a)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic timeout_fail(input string what);
        checks++;
        errors++;
        $display("FAIL %s: handshake timed out after %0d cycles, required completion", what, TIMEOUT);
    endtask

    task automatic axi_write(input logic [11:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        int n;
        resp = 2'bxx;
        axi.awaddr  = addr;
        axi.awvalid = 1'b1;
        axi.wdata   = data;
        axi.wstrb   = strb;
        axi.wvalid  = 1'b1;
        axi.bready  = 1'b1;
        n = 0;
        while (axi.awready !== 1'b1 && n < TIMEOUT) begin tick(); n++; end
        if (n >= TIMEOUT) timeout_fail("aw");
        tick();
        axi.awvalid = 1'b0;
        n = 0;
        while (axi.wready !== 1'b1 && n < TIMEOUT) begin tick(); n++; end
        if (n >= TIMEOUT) timeout_fail("w");
        tick();
        axi.wvalid = 1'b0;
        n = 0;
        while (axi.bvalid !== 1'b1 && n < TIMEOUT) begin tick(); n++; end
        if (n >= TIMEOUT) timeout_fail("b");
        resp = axi.bresp;
        tick();
        axi.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [11:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        int n;
        axi.araddr  = addr;
        axi.arvalid = 1'b1;
        n = 0;
        while (axi.arready !== 1'b1 && n < TIMEOUT) begin tick(); n++; end
        if (n >= TIMEOUT) timeout_fail("ar");
        tick();
        axi.arvalid = 1'b0;
        axi.rready  = 1'b1;
        n = 0;
        while (axi.rvalid !== 1'b1 && n < TIMEOUT) begin tick(); n++; end
        if (n >= TIMEOUT) timeout_fail("r");
        data = axi.rdata;
        resp = axi.rresp;
        tick();
        axi.rready = 1'b0;
    endtask

    task automatic pulse_ready();
        ap_ready = 1'b1;
        tick();
        ap_ready = 1'b0;
        tick();
    endtask

    task automatic pulse_done();
        ap_done = 1'b1;
        tick();
        ap_done = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        ap_rst = 1'b1;
        tick();
        tick();
        checks++;
        if (axi.awready !== 1'b0 || axi.arready !== 1'b0 || axi.bvalid !== 1'b0 || axi.rvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake: aw=%b ar=%b b=%b r=%b, required all 0",
                     axi.awready, axi.arready, axi.bvalid, axi.rvalid);
        end
        checks++;
        if (ap_start !== 1'b0 || interrupt !== 1'b0 || ctrl_length !== 32'h0 || a !== 64'h0) begin
            errors++;
            $display("FAIL reset_outputs: start=%b irq=%b len=%h a=%h, required 0",
                     ap_start, interrupt, ctrl_length, a);
        end
        ap_rst = 1'b0;
        tick();
        checks++;
        if (axi.awready !== 1'b1 || axi.arready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: awready=%b arready=%b, required 1 1", axi.awready, axi.arready);
        end
    endtask

    task automatic test_length();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(12'h010, 32'hFFFF_FFFF, 4'hF, r);
        checks++;
        if (r !== 2'b00) begin errors++; $display("FAIL len_bresp: got %b, required 00", r); end
        axi_read(12'h010, d, r);
        checks++;
        if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL len_read: got %h, required ffffffff", d); end
        checks++;
        if (r !== 2'b00) begin errors++; $display("FAIL len_rresp: got %b, required 00", r); end
        axi_write(12'h010, 32'h0000_0000, 4'b0001, r);
        axi_read(12'h010, d, r);
        checks++;
        if (d !== 32'hFFFF_FF00) begin errors++; $display("FAIL len_strb: got %h, required ffffff00", d); end
        checks++;
        if (ctrl_length !== 32'hFFFF_FF00) begin errors++; $display("FAIL len_port: got %h, required ffffff00", ctrl_length); end
    endtask

    task automatic test_pointer();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(12'h018, 32'hABCD_E000, 4'hF, r);
        axi_write(12'h01C, 32'h1234_5678, 4'hF, r);
        checks++;
        if (a !== 64'h1234_5678_ABCD_E000) begin errors++; $display("FAIL ptr_port: got %h, required 12345678abcde000", a); end
        axi_read(12'h018, d, r);
        checks++;
        if (d !== 32'hABCD_E000) begin errors++; $display("FAIL ptr_lo: got %h, required abcde000", d); end
        axi_read(12'h01C, d, r);
        checks++;
        if (d !== 32'h1234_5678) begin errors++; $display("FAIL ptr_hi: got %h, required 12345678", d); end
    endtask

    task automatic test_unmapped();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(12'h020, 32'hDEAD_BEEF, 4'hF, r);
        axi_read(12'h020, d, r);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h, required 0", d); end
        axi_read(12'h810, d, r);
        checks++;
        if (d !== 32'hFFFF_FF00) begin errors++; $display("FAIL alias_read: got %h, required ffffff00", d); end
    endtask

    task automatic test_start_done();
        logic [31:0] d;
        logic [1:0]  r;
        ap_idle = 1'b0;
        tick();
        axi_write(12'h000, 32'h1, 4'hF, r);
        checks++;
        if (ap_start !== 1'b1) begin errors++; $display("FAIL start_set: got %b, required 1", ap_start); end
        axi_read(12'h000, d, r);
        checks++;
        if (d !== 32'h01) begin errors++; $display("FAIL ctrl_running: got %h, required 01", d); end
        pulse_ready();
        checks++;
        if (ap_start !== 1'b0) begin errors++; $display("FAIL start_clear: got %b, required 0", ap_start); end
        ap_idle = 1'b1;
        pulse_done();
        axi_read(12'h000, d, r);
        checks++;
        if (d !== 32'h0E) begin errors++; $display("FAIL ctrl_done: got %h, required 0e", d); end
        axi_read(12'h000, d, r);
        checks++;
        if (d !== 32'h04) begin errors++; $display("FAIL ctrl_cor: got %h, required 04", d); end
    endtask

    task automatic test_auto_restart();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(12'h004, 32'h1, 4'hF, r);
        axi_write(12'h008, 32'h1, 4'hF, r);
        axi_write(12'h000, 32'h81, 4'hF, r);
        pulse_ready();
        checks++;
        if (ap_start !== 1'b1) begin errors++; $display("FAIL auto_restart_hold: got %b, required 1", ap_start); end
        checks++;
        if (interrupt !== 1'b0) begin errors++; $display("FAIL irq_masked: got %b, required 0", interrupt); end
        pulse_done();
        checks++;
        if (interrupt !== 1'b1) begin errors++; $display("FAIL irq_done: got %b, required 1", interrupt); end
        axi_read(12'h00C, d, r);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL isr_read: got %h, required 1", d); end
        axi_write(12'h00C, 32'h1, 4'hF, r);
        checks++;
        if (interrupt !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b, required 0", interrupt); end
        axi_write(12'h000, 32'h0, 4'hF, r);
        pulse_ready();
        checks++;
        if (ap_start !== 1'b0) begin errors++; $display("FAIL restart_off: got %b, required 0", ap_start); end
    endtask

    task automatic test_backpressure();
        logic [31:0] d;
        logic [1:0]  r;
        logic [31:0] first;
        int bad_b, bad_aw, bad_r;
        axi.awaddr  = 12'h010;
        axi.awvalid = 1'b1;
        axi.wdata   = 32'hCAFE_F00D;
        axi.wstrb   = 4'hF;
        axi.wvalid  = 1'b1;
        axi.bready  = 1'b0;
        tick();
        tick();
        axi.wvalid = 1'b0;
        bad_b = 0;
        bad_aw = 0;
        for (int i = 0; i < 5; i++) begin
            if (axi.bvalid !== 1'b1) bad_b++;
            if (axi.awready !== 1'b0) bad_aw++;
            tick();
        end
        checks++;
        if (bad_b != 0) begin errors++; $display("FAIL bvalid_hold: dropped %0d cycles, required 0", bad_b); end
        checks++;
        if (bad_aw != 0) begin errors++; $display("FAIL no_second_aw: awready high %0d cycles, required 0", bad_aw); end
        axi.awvalid = 1'b0;
        axi.bready  = 1'b1;
        tick();
        axi.bready = 1'b0;
        checks++;
        if (axi.bvalid !== 1'b0) begin errors++; $display("FAIL bvalid_release: got %b, required 0", axi.bvalid); end

        axi.araddr  = 12'h010;
        axi.arvalid = 1'b1;
        axi.rready  = 1'b0;
        tick();
        tick();
        axi.arvalid = 1'b0;
        first = axi.rdata;
        bad_r = 0;
        for (int i = 0; i < 5; i++) begin
            if (axi.rvalid !== 1'b1 || axi.rdata !== 32'hCAFE_F00D) bad_r++;
            tick();
        end
        checks++;
        if (first !== 32'hCAFE_F00D || bad_r != 0) begin
            errors++;
            $display("FAIL rdata_hold: first=%h unstable=%0d, required cafef00d 0", first, bad_r);
        end
        axi.rready = 1'b1;
        tick();
        axi.rready = 1'b0;
        axi_read(12'h010, d, r);
        checks++;
        if (d !== 32'hCAFE_F00D) begin errors++; $display("FAIL after_bp: got %h, required cafef00d", d); end
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(12'h000, 32'h1, 4'hF, r);
        axi.awaddr  = 12'h010;
        axi.awvalid = 1'b1;
        axi.wdata   = 32'h5555_AAAA;
        axi.wstrb   = 4'hF;
        axi.wvalid  = 1'b0;
        tick();
        tick();
        axi.awvalid = 1'b0;
        ap_rst = 1'b1;
        #1;
        checks++;
        if (axi.awready !== 1'b0 || axi.wready !== 1'b0 || axi.bvalid !== 1'b0 ||
            axi.arready !== 1'b0 || axi.rvalid !== 1'b0 || axi.rdata !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_bus: aw=%b w=%b b=%b ar=%b r=%b rd=%h, required all 0",
                     axi.awready, axi.wready, axi.bvalid, axi.arready, axi.rvalid, axi.rdata);
        end
        checks++;
        if (ap_start !== 1'b0 || interrupt !== 1'b0 || ctrl_length !== 32'h0 || a !== 64'h0) begin
            errors++;
            $display("FAIL rst_mid_out: start=%b irq=%b len=%h a=%h, required 0",
                     ap_start, interrupt, ctrl_length, a);
        end
        tick();
        ap_rst = 1'b0;
        tick();
        checks++;
        if (axi.awready !== 1'b1) begin errors++; $display("FAIL rst_mid_recover: awready=%b, required 1", axi.awready); end
        axi_read(12'h010, d, r);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL rst_mid_len: got %h, required 0", d); end
    endtask

    initial begin
        ap_rst      = 1'b1;
        ap_done     = 1'b0;
        ap_idle     = 1'b0;
        ap_ready    = 1'b0;
        axi.awvalid = 1'b0;
        axi.awaddr  = '0;
        axi.wvalid  = 1'b0;
        axi.wdata   = '0;
        axi.wstrb   = '0;
        axi.bready  = 1'b0;
        axi.arvalid = 1'b0;
        axi.araddr  = '0;
        axi.rready  = 1'b0;

        test_reset();
        test_length();
        test_pointer();
        test_unmapped();
        test_start_done();
        test_auto_restart();
        test_backpressure();
        test_reset_mid_write();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
